// File: rtl/audio_pkg.sv
// Shared constants and helpers for the audio serialiser blocks.
package audio_pkg;

    localparam logic MODE_I2S = 1'b0;
    localparam logic MODE_LJ  = 1'b1;

    function automatic int frame_bits(input int num_ch, input int slot_w);
        return num_ch * slot_w;
    endfunction

endpackage

// File: rtl/i2s_clk_gen.sv
// Bit-clock divider: sclk toggles every P clk cycles, with P latched at each frame load.
module i2s_clk_gen #(
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PRESCALE_W-1:0] prescaler,
    input  logic                  load,
    output logic                  sclk,
    output logic                  sclk_rise,
    output logic                  sclk_fall
);

    logic [PRESCALE_W-1:0] p_reg;
    logic [PRESCALE_W-1:0] p_live;
    logic [PRESCALE_W-1:0] p_eff;
    logic [PRESCALE_W-1:0] div_cnt;
    logic                  started;
    logic                  wrap;

    // Until the first frame load there is no latched value, so the live input sets the pace.
    always_comb begin
        p_live = (prescaler == '0) ? PRESCALE_W'(1) : prescaler;
        p_eff  = started ? p_reg : p_live;
        wrap   = (div_cnt >= p_eff - PRESCALE_W'(1));
    end

    assign sclk_rise = wrap & ~sclk;
    assign sclk_fall = wrap & sclk;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            sclk    <= 1'b0;
            p_reg   <= PRESCALE_W'(1);
            started <= 1'b0;
        end else begin
            if (wrap) begin
                div_cnt <= '0;
                sclk    <= ~sclk;
            end else begin
                div_cnt <= div_cnt + PRESCALE_W'(1);
            end
            if (load) begin
                p_reg   <= p_live;
                started <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2s_tdm_tx.sv
// I2S / left-justified / TDM serialiser with a one-frame holding register and underrun flag.
module i2s_tdm_tx #(
    parameter int SAMPLE_W   = 16,
    parameter int SLOT_W     = 16,
    parameter int NUM_CH     = 2,
    parameter int PRESCALE_W = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [PRESCALE_W-1:0]        prescaler,
    input  logic                         mode,
    input  logic [NUM_CH*SAMPLE_W-1:0]   in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic                         sclk,
    output logic                         lrclk,
    output logic                         sdata,
    output logic                         frame_start,
    output logic                         underrun
);

    import audio_pkg::*;

    localparam int FRAME  = frame_bits(NUM_CH, SLOT_W);
    localparam int CNT_W  = $clog2(FRAME);
    localparam int DATA_W = NUM_CH * SAMPLE_W;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME - 1);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(FRAME / 2);

    // Frame bit 0 (channel 0 MSB) sits at the top so the shifter can always shift left.
    function automatic logic [FRAME-1:0] pack_frame(input logic [DATA_W-1:0] d);
        logic [FRAME-1:0] f;
        f = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            for (int b = 0; b < SAMPLE_W; b++) begin
                f[FRAME - k*SLOT_W - SAMPLE_W + b] = d[k*SAMPLE_W + b];
            end
        end
        return f;
    endfunction

    function automatic logic lr_level(input logic [CNT_W-1:0] bc, input logic m);
        logic [CNT_W-1:0] nxt;
        nxt = (bc == LAST) ? '0 : bc + CNT_W'(1);
        return (m == MODE_LJ) ? (bc >= HALF) : (nxt >= HALF);
    endfunction

    logic [DATA_W-1:0] hold_data;
    logic [FRAME-1:0]  shifter;
    logic [FRAME-1:0]  frame_new;
    logic [CNT_W-1:0]  bit_cnt;
    logic [CNT_W-1:0]  bit_next;
    logic              mode_reg;
    logic              mode_sel;
    logic              load;
    logic              accept;
    logic              sclk_fall;
    logic              rise_unused;

    i2s_clk_gen #(
        .PRESCALE_W (PRESCALE_W)
    ) u_clk_gen (
        .clk       (clk),
        .rst       (rst),
        .prescaler (prescaler),
        .load      (load),
        .sclk      (sclk),
        .sclk_rise (rise_unused),
        .sclk_fall (sclk_fall)
    );

    always_comb begin
        load      = sclk_fall && (bit_cnt == LAST);
        accept    = in_valid && in_ready;
        bit_next  = (bit_cnt == LAST) ? '0 : bit_cnt + CNT_W'(1);
        mode_sel  = load ? mode : mode_reg;
        frame_new = in_ready ? '0 : pack_frame(hold_data);
    end

    // A frame accepted in the same cycle as a mute load waits for the next frame; no bypass.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_data <= '0;
            in_ready  <= 1'b1;
        end else if (accept) begin
            hold_data <= in_data;
            in_ready  <= 1'b0;
        end else if (load) begin
            in_ready  <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shifter     <= '0;
            bit_cnt     <= LAST;
            sdata       <= 1'b0;
            lrclk       <= 1'b0;
            mode_reg    <= MODE_I2S;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            frame_start <= load;
            underrun    <= load && in_ready;
            if (load) begin
                mode_reg <= mode;
            end
            if (sclk_fall) begin
                bit_cnt <= bit_next;
                lrclk   <= lr_level(bit_next, mode_sel);
                if (load) begin
                    sdata   <= frame_new[FRAME-1];
                    shifter <= {frame_new[FRAME-2:0], 1'b0};
                end else begin
                    sdata   <= shifter[FRAME-1];
                    shifter <= {shifter[FRAME-2:0], 1'b0};
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_tdm_tx.sv
// Scoreboard bench: stimulus queues expected serial bits, monitors pop them on each sclk rise.
module tb_i2s_tdm_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  prescaler;
    logic        mode;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready, sclk, lrclk, sdata, frame_start, underrun;

    logic [7:0]  prescaler4;
    logic        mode4;
    logic [95:0] in_data4;
    logic        in_valid4;
    logic        in_ready4, sclk4, lrclk4, sdata4, frame_start4, underrun4;

    typedef struct packed {
        logic sd;
        logic lr;
    } bit_t;

    bit_t exp_q[$];
    bit_t exp_q4[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc;
    int   accepts = 0;
    logic mon_en = 1'b0;

    i2s_tdm_tx dut (
        .clk         (clk),
        .rst         (rst),
        .prescaler   (prescaler),
        .mode        (mode),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .sclk        (sclk),
        .lrclk       (lrclk),
        .sdata       (sdata),
        .frame_start (frame_start),
        .underrun    (underrun)
    );

    i2s_tdm_tx #(
        .SAMPLE_W   (24),
        .SLOT_W     (32),
        .NUM_CH     (4),
        .PRESCALE_W (8)
    ) dut4 (
        .clk         (clk),
        .rst         (rst),
        .prescaler   (prescaler4),
        .mode        (mode4),
        .in_data     (in_data4),
        .in_valid    (in_valid4),
        .in_ready    (in_ready4),
        .sclk        (sclk4),
        .lrclk       (lrclk4),
        .sdata       (sdata4),
        .frame_start (frame_start4),
        .underrun    (underrun4)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cyc %0d)", name, actual, expected, cyc);
        end
    endtask

    // Serial word is {L, R}; bit i is sent at frame position i.
    task automatic pushFrame(input logic [31:0] word, input logic m);
        bit_t e;
        for (int i = 0; i < 32; i++) begin
            e.sd = word[31-i];
            e.lr = m ? (i >= 16) : (((i + 1) % 32) >= 16);
            exp_q.push_back(e);
        end
    endtask

    task automatic applyStimulus(input int at_cyc, input logic [15:0] l, input logic [15:0] r,
                                 input logic m, input logic do_send, input logic expect_out);
        while (cyc < at_cyc) begin
            @(posedge clk);
            #2;
        end
        mode = m;
        if (do_send) begin
            in_data  = {r, l};
            in_valid = 1'b1;
            @(posedge clk);
            #2;
            in_valid = 1'b0;
        end
        if (expect_out) pushFrame(do_send ? {l, r} : 32'h0, m);
    endtask

    function automatic logic exp_fs(input int c);
        return (c >= 4) && (c <= 1028) && (((c - 4) % 128) == 0);
    endfunction

    // Monitor for the stereo instance
    initial begin
        bit_t e;
        logic prev_sclk;
        int   prev_rise;
        prev_sclk = 1'b0;
        prev_rise = -1;
        forever begin
            @(negedge clk);
            if (!rst && mon_en) begin
                checkOutput("frame_start", frame_start, exp_fs(cyc));
                checkOutput("underrun", underrun, (cyc == 132) || (cyc == 900));
                if (cyc >= 389 && cyc <= 653)
                    checkOutput("in_ready", in_ready, (cyc == 516) || (cyc == 644));
                if (cyc >= 388 && cyc <= 653 && in_valid && in_ready)
                    accepts++;
                if (sclk && !prev_sclk) begin
                    if (cyc > 4) begin
                        if (exp_q.size() == 0) begin
                            checkOutput("scoreboard_empty", 32'd1, 32'd0);
                        end else begin
                            e = exp_q.pop_front();
                            checkOutput("sdata", sdata, e.sd);
                            checkOutput("lrclk", lrclk, e.lr);
                        end
                    end
                    if (prev_rise < 0)
                        checkOutput("first_rise_cycle", cyc, 2);
                    else if (prev_rise >= 1028)
                        checkOutput("sclk_period_p5", cyc - prev_rise, 10);
                    else if (cyc < 1028)
                        checkOutput("sclk_period_p2", cyc - prev_rise, 4);
                    prev_rise = cyc;
                end
                prev_sclk = sclk;
            end
        end
    end

    // Monitor for the four-channel TDM instance
    initial begin
        bit_t e;
        logic prev_sclk4;
        prev_sclk4 = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && mon_en) begin
                checkOutput("frame_start4", frame_start4, (cyc >= 2) && (((cyc - 2) % 256) == 0));
                checkOutput("underrun4", underrun4, (cyc >= 258) && (((cyc - 2) % 256) == 0));
                if (sclk4 && !prev_sclk4 && cyc > 2 && exp_q4.size() > 0) begin
                    e = exp_q4.pop_front();
                    checkOutput("sdata4", sdata4, e.sd);
                    checkOutput("lrclk4", lrclk4, e.lr);
                end
                prev_sclk4 = sclk4;
            end
        end
    end

    initial begin
        logic [127:0] w4;
        bit_t         e;
        prescaler  = 8'd2;
        mode       = 1'b0;
        in_data    = '0;
        in_valid   = 1'b0;
        prescaler4 = 8'd0;
        mode4      = 1'b1;
        in_data4   = '0;
        in_valid4  = 1'b0;

        repeat (3) @(posedge clk);
        #2;
        checkOutput("rst_sclk", sclk, 0);
        checkOutput("rst_lrclk", lrclk, 0);
        checkOutput("rst_sdata", sdata, 0);
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_frame_start", frame_start, 0);
        checkOutput("rst_underrun", underrun, 0);
        checkOutput("rst_in_ready4", in_ready4, 1);
        rst    = 1'b0;
        mon_en = 1'b1;

        // Four-channel frame: 24-bit samples, 8 zero pad bits per 32-bit slot, then a mute frame.
        in_data4  = {24'h800000, 24'h000001, 24'hABCDEF, 24'h123456};
        in_valid4 = 1'b1;
        w4 = 128'h12345600_ABCDEF00_00000100_80000000;
        for (int i = 0; i < 256; i++) begin
            e.sd = (i < 128) ? w4[127-i] : 1'b0;
            e.lr = ((i % 128) >= 64);
            exp_q4.push_back(e);
        end

        applyStimulus(0, 16'hA5F0, 16'h0F0F, 1'b0, 1'b1, 1'b1);
        in_valid4 = 1'b0;
        applyStimulus(10,  16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
        applyStimulus(150, 16'hA5F0, 16'h0F0F, 1'b1, 1'b1, 1'b1);
        applyStimulus(300, 16'h7FFE, 16'h8001, 1'b0, 1'b1, 1'b1);

        // Continuous valid across frames 3..5: one accept per frame, frames 4..6 carry it.
        while (cyc < 388) begin
            @(posedge clk);
            #2;
        end
        in_data  = {16'hFFFF, 16'h1234};
        in_valid = 1'b1;
        repeat (3) pushFrame({16'h1234, 16'hFFFF}, 1'b0);
        while (cyc < 654) begin
            @(posedge clk);
            #2;
        end
        in_valid = 1'b0;
        checkOutput("accepts_per_frame", accepts, 3);

        applyStimulus(660, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
        while (cyc < 950) begin
            @(posedge clk);
            #2;
        end
        prescaler = 8'd5;
        applyStimulus(950,  16'hA5F0, 16'h0F0F, 1'b0, 1'b1, 1'b1);
        applyStimulus(1050, 16'h7FFE, 16'h8001, 1'b0, 1'b1, 1'b0);

        while (cyc < 1104) begin
            @(posedge clk);
            #2;
        end
        mon_en = 1'b0;
        checkOutput("pre_rst_in_ready", in_ready, 0);
        checkOutput("pre_rst_sclk", sclk, 1);
        rst = 1'b1;
        #1;
        checkOutput("async_rst_sclk", sclk, 0);
        checkOutput("async_rst_lrclk", lrclk, 0);
        checkOutput("async_rst_sdata", sdata, 0);
        checkOutput("async_rst_in_ready", in_ready, 1);
        checkOutput("async_rst_frame_start", frame_start, 0);
        checkOutput("async_rst_underrun", underrun, 0);
        checkOutput("async_rst_sclk4", sclk4, 0);
        repeat (3) @(posedge clk);
        #2;
        checkOutput("held_rst_sclk", sclk, 0);
        checkOutput("held_rst_in_ready", in_ready, 1);

        checkOutput("tdm_scoreboard_drained", exp_q4.size(), 0);
        checkOutput("stereo_frames_consumed", (exp_q.size() <= 32), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i2s_tdm_tx.md
# i2s_tdm_tx

Parametrised successor to the fixed stereo `i2s_tx` serialiser that drives the MAX9850 headphone DAC. It accepts whole audio frames of `NUM_CH` samples through a valid/ready handshake, buffers one frame ahead, and serialises them MSB-first on `sclk`/`lrclk`/`sdata`. It supports I2S or left-justified framing, configurable slot width and TDM channel counts. Underruns are detected and flagged. It sits in the audio clock domain (`clk_114`) between the Minimig audio mixer and the DAC pins.

## Interface
Parameters:
- `SAMPLE_W`, default 16: bits per sample.
- `SLOT_W`, default 16: bits per channel slot. Must be ≥ `SAMPLE_W`; excess bits are zero-padded after the sample LSB.
- `NUM_CH`, default 2: channels per frame. Must be even and ≥ 2.
- `PRESCALE_W`, default 8: width of the `prescaler` input.

Ports:
- `clk`, in, 1: audio clock. Single clock domain.
- `rst`, in, 1: reset, asynchronous, active-high.
- `prescaler`, in, `PRESCALE_W`: sclk half-period in `clk` cycles. A value of 0 is treated as 1.
- `mode`, in, 1: 0 = I2S (one-bit delay), 1 = left-justified.
- `in_data`, in, `NUM_CH*SAMPLE_W`: frame data. Channel 0 occupies the LSB end.
- `in_valid`, in, 1: frame offered.
- `in_ready`, out, 1: holding register empty.
- `sclk`, out, 1: bit clock.
- `lrclk`, out, 1: word/frame select.
- `sdata`, out, 1: serial data.
- `frame_start`, out, 1: one-`clk` pulse when a frame is loaded into the shifter.
- `underrun`, out, 1: one-`clk` pulse when a load finds the holding register empty.

## Operation
- Let FRAME = `NUM_CH*SLOT_W` and P = max(`prescaler`,1). P and `mode` are latched at each frame load. Changes take effect only at frame boundaries.
- Divider:
  - `div_cnt` counts from 0 to P-1. At P-1 it wraps and `sclk` toggles.
  - The sclk period is 2P clk cycles.
- Bit counter:
  - `bit_cnt` runs from 0 to FRAME-1 and advances on every sclk falling transition. It wraps FRAME-1 → 0.
  - Reset value is FRAME-1, so the first falling transition starts frame bit 0.
- Frame load (when `bit_cnt` wraps to 0):
  - If the holding register is full, it is copied into the shifter, the holding register becomes empty, and `frame_start` pulses.
  - If the holding register is empty, the shifter is loaded with all zeros (mute), and both `underrun` and `frame_start` pulse.
- Shifter layout:
  - Slot k carries channel k, MSB first.
  - `SLOT_W-SAMPLE_W` zero bits follow the LSB of each sample.
- `sdata` presents frame bit `bit_cnt`. It updates in the same clk cycle as the sclk falling transition and is stable across the rising edge.
- lrclk:
  - Left-justified: lrclk = (`bit_cnt` ≥ FRAME/2).
  - I2S: lrclk = (((`bit_cnt`+1) mod FRAME) ≥ FRAME/2). lrclk therefore leads the MSB by one sclk.
- Handshake:
  - A transfer occurs when `in_valid` and `in_ready` are both high on a clk edge.
  - `in_ready` falls in the cycle after the accept. It rises in the cycle after the holding register is consumed.
  - `in_data` is captured only on transfer.
- Simultaneous accept and load with an empty holding register: the load mutes and flags `underrun`. The accepted frame goes to the holding register for the next frame; there is no bypass.
- Reset mid-frame: all state is cleared immediately. No partial frame is resumed.

## Timing
- Reset values:
  - `sclk`=0, `lrclk`=0, `sdata`=0.
  - `in_ready`=1, `frame_start`=0, `underrun`=0.
  - Shifter and holding register are zero; holding register is marked empty.
- After rst deasserts:
  - First sclk rise occurs at clk cycle P.
  - First fall occurs at cycle 2P. This fall loads frame 0, which mutes and flags `underrun` unless a frame was accepted beforehand.
- Latency: a frame accepted during frame n is output as frame n+1, starting at the next wrap.
- All outputs are registered; there is no combinational path from input to output.

## Structure
- `audio_pkg` holds the `MODE_I2S`/`MODE_LJ` constants and a function computing FRAME from the parameters.
- Sub-module `i2s_clk_gen` contains the prescaler divider. It outputs `sclk` plus one-cycle `sclk_rise` and `sclk_fall` strobes, and latches P on the `load` input.
- The top level contains the handshake, holding register, shifter, and `bit_cnt`/lrclk logic.

## Test plan
- Defaults, P=2, I2S mode, L=16'hA5F0, R=16'h0F0F, pre-loaded:
  - Required: lrclk falls one sclk before L's MSB.
  - Required: 32 bits serialise as A5F0 then 0F0F.
  - Required: sclk period is 4 clk cycles.
- Left-justified mode, same data: lrclk edges are aligned with the MSB of each slot.
- `NUM_CH`=4, `SLOT_W`=32, `SAMPLE_W`=24, channels 0x123456/0xABCDEF/0x000001/0x800000:
  - Required: 128 bits per frame.
  - Required: each slot is 24 data bits followed by 8 zeros.
  - Required: lrclk is high for slots 2 and 3.
- No `in_valid` after the first frame:
  - Required: the second frame is all zeros.
  - Required: `underrun` is a single-clk pulse.
  - Required: `frame_start` continues every frame.
- `in_valid` held high continuously:
  - Required: exactly one accept per frame.
  - Required: `in_ready` is low from the cycle after the accept until the cycle after the load.
  - Required: no underruns.
- Change `prescaler` 2→5 mid-frame, then assert rst mid-frame:
  - Required: the period changes only at the next frame load.
  - Required: rst clears all outputs asynchronously to their reset values.
